divisor_sequencial: RTL and testbench

DIVISOR_SEQUENCIAL -- requirements
Module: divisor_sequencial

---
 rtl/divisor_sequencial.sv | 147 ++++++++++++++
 tb/tb_divisor_sequencial.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_sequencial.sv
// -----------------------------------------------------------------------------
// divisor_sequencial
//   Unsigned sequential divider using restoring shift-subtract.
//   One quotient bit is produced per clock, MSB first, so a division with a
//   non-zero divisor takes LARGURA cycles in DIVIDE plus one cycle in FIM.
//   A zero divisor skips DIVIDE and goes straight to FIM with DivZero set.
//
// Handshake (start/completion):
//   - A start is accepted only in OCIOSO, on a rising Clock edge with
//     Iniciar=1. Dividendo/Divisor are captured on that edge and never
//     re-sampled. Iniciar is ignored in DIVIDE and FIM; nothing is queued.
//   - Pronto is a one-cycle pulse during FIM. Quociente/Resto/DivZero are
//     valid while Pronto is high and hold until the next completion
//     (DivZero is cleared when a non-zero-divisor start is accepted).
//   - Ocupado is high in every state except OCIOSO.
//
// Parameters:
//   LARGURA       operand/result width in bits (>= 2)
//
// Ports:
//   Clock         system clock, rising edge
//   Reset         asynchronous active-low reset
//   Iniciar       start request
//   Dividendo     unsigned dividend
//   Divisor       unsigned divisor
//   Quociente     quotient of the last completed operation
//   Resto         remainder of the last completed operation
//   Ocupado       FSM not in OCIOSO
//   Pronto        one-cycle completion pulse
//   DivZero       last completed operation had Divisor = 0
//   o_dbg_estado  current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module divisor_sequencial #(
  parameter int LARGURA = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Iniciar,
  input  logic [LARGURA-1:0] Dividendo,
  input  logic [LARGURA-1:0] Divisor,
  output logic [LARGURA-1:0] Quociente,
  output logic [LARGURA-1:0] Resto,
  output logic               Ocupado,
  output logic               Pronto,
  output logic               DivZero,
  output logic [1:0]         o_dbg_estado
);

  localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    DIVIDE = 2'd1,
    FIM    = 2'd2
  } estado_t;

  estado_t            r_estado;
  // r_dq starts as the dividend; each iteration shifts its MSB out into the
  // partial remainder and shifts the new quotient bit into its LSB, so after
  // LARGURA iterations it holds the quotient.
  logic [LARGURA-1:0] r_dq;
  logic [LARGURA-1:0] r_divisor;
  // Partial remainder is always < divisor between iterations, so LARGURA bits
  // suffice for storage; the shifted value needs one extra bit.
  logic [LARGURA-1:0] r_parcial;
  logic [CW-1:0]      r_contador;

  logic [LARGURA:0]   w_shift;
  logic               w_ge;
  logic [LARGURA-1:0] w_sub;
  logic [LARGURA-1:0] w_parcial_novo;
  logic [LARGURA-1:0] w_dq_novo;
  logic               w_ultima;

  assign w_shift        = {r_parcial, r_dq[LARGURA-1]};
  assign w_ge           = (w_shift >= {1'b0, r_divisor});
  // When w_ge holds the true difference is < divisor, so the low LARGURA bits
  // of the modular subtraction are exact.
  assign w_sub          = w_shift[LARGURA-1:0] - r_divisor;
  assign w_parcial_novo = w_ge ? w_sub : w_shift[LARGURA-1:0];
  assign w_dq_novo      = {r_dq[LARGURA-2:0], w_ge};
  assign w_ultima       = (r_contador == CW'(LARGURA - 1));

  assign o_dbg_estado   = r_estado;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_estado   <= OCIOSO;
      r_dq       <= '0;
      r_divisor  <= '0;
      r_parcial  <= '0;
      r_contador <= '0;
      Quociente  <= '0;
      Resto      <= '0;
      Ocupado    <= 1'b0;
      Pronto     <= 1'b0;
      DivZero    <= 1'b0;
    end else begin
      // Pronto is a pulse: only the edge entering FIM raises it.
      Pronto <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (Iniciar) begin
            r_dq       <= Dividendo;
            r_divisor  <= Divisor;
            r_parcial  <= '0;
            r_contador <= '0;
            Ocupado    <= 1'b1;
            if (Divisor == '0) begin
              Quociente <= '1;
              Resto     <= Dividendo;
              DivZero   <= 1'b1;
              Pronto    <= 1'b1;
              r_estado  <= FIM;
            end else begin
              DivZero  <= 1'b0;
              r_estado <= DIVIDE;
            end
          end
        end

        DIVIDE: begin
          r_parcial  <= w_parcial_novo;
          r_dq       <= w_dq_novo;
          r_contador <= r_contador + 1'b1;
          if (w_ultima) begin
            Quociente <= w_dq_novo;
            Resto     <= w_parcial_novo;
            Pronto    <= 1'b1;
            r_estado  <= FIM;
          end
        end

        FIM: begin
          Ocupado  <= 1'b0;
          r_estado <= OCIOSO;
        end

        default: begin
          Ocupado  <= 1'b0;
          r_estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_sequencial.sv
module tb_divisor_sequencial;

  localparam int L = 4;
  localparam int EW = 2 * L + 1;

  // ---------------- clock / reset ----------------
  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic         Iniciar = 1'b0;
  logic [L-1:0] Dividendo = '0;
  logic [L-1:0] Divisor = '0;
  logic [L-1:0] Quociente;
  logic [L-1:0] Resto;
  logic         Ocupado;
  logic         Pronto;
  logic         DivZero;
  logic [1:0]   o_dbg_estado;

  always #5 Clock = ~Clock;

  divisor_sequencial #(.LARGURA(L)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Iniciar      (Iniciar),
    .Dividendo    (Dividendo),
    .Divisor      (Divisor),
    .Quociente    (Quociente),
    .Resto        (Resto),
    .Ocupado      (Ocupado),
    .Pronto       (Pronto),
    .DivZero      (DivZero),
    .o_dbg_estado (o_dbg_estado)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int pronto_cnt = 0;
  int expected_cnt = 0;
  logic prev_pronto = 1'b0;

  // Scoreboard entries: {DivZero, Quociente, Resto}
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: plain arithmetic from the division rules.
  function automatic logic [EW-1:0] model(input int a, input int b);
    logic [L-1:0] q;
    logic [L-1:0] r;
    logic         dz;
    if (b == 0) begin
      q  = '1;
      r  = L'(a);
      dz = 1'b1;
    end else begin
      q  = L'(a / b);
      r  = L'(a % b);
      dz = 1'b0;
    end
    return {dz, q, r};
  endfunction

  // ---------------- completion monitor ----------------
  always @(negedge Clock) begin
    if (Reset) begin
      if (Pronto) begin
        pronto_cnt++;
        check("pronto_implies_ocupado", int'(Ocupado), 1);
        check("pronto_single_cycle", int'(prev_pronto), 0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pronto: got pulse expected none");
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("quociente", int'(Quociente), int'(e[2*L-1:L]));
          check("resto", int'(Resto), int'(e[L-1:0]));
          check("divzero", int'(DivZero), int'(e[2*L]));
        end
      end
      prev_pronto = Pronto;
    end else begin
      prev_pronto = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Starts one operation, waits for Pronto and checks latency and the
  // return to idle. Result values are checked by the monitor.
  task automatic run_op(input int a, input int b, input int exp_lat, input string name);
    int  lat;
    bit  found;
    exp_q.push_back(model(a, b));
    expected_cnt++;
    @(negedge Clock);
    Iniciar   = 1'b1;
    Dividendo = L'(a);
    Divisor   = L'(b);
    @(posedge Clock);
    #1 Iniciar = 1'b0;
    lat   = 0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (i == 0) check({name, "_ocupado_after_start"}, int'(Ocupado), 1);
      if (Pronto) begin
        found = 1'b1;
        break;
      end
      @(posedge Clock);
      lat++;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no pronto expected pronto within 20 cycles", name);
    end else begin
      check({name, "_latency"}, lat, exp_lat);
      @(negedge Clock);
      check({name, "_pronto_dropped"}, int'(Pronto), 0);
      check({name, "_idle_after_fim"}, int'(Ocupado), 0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dz;
    int lat;
  } vec_t;

  vec_t vecs[9];
  int   order[256];

  initial begin
    vecs[0] = '{a: 13, b: 3,  q: 4,  r: 1, dz: 0, lat: L};
    vecs[1] = '{a: 15, b: 1,  q: 15, r: 0, dz: 0, lat: L};
    vecs[2] = '{a: 0,  b: 7,  q: 0,  r: 0, dz: 0, lat: L};
    vecs[3] = '{a: 7,  b: 8,  q: 0,  r: 7, dz: 0, lat: L};
    vecs[4] = '{a: 15, b: 15, q: 1,  r: 0, dz: 0, lat: L};
    vecs[5] = '{a: 9,  b: 0,  q: 15, r: 9, dz: 1, lat: 0};
    vecs[6] = '{a: 6,  b: 2,  q: 3,  r: 0, dz: 0, lat: L};
    vecs[7] = '{a: 11, b: 2,  q: 5,  r: 1, dz: 0, lat: L};
    vecs[8] = '{a: 1,  b: 15, q: 0,  r: 1, dz: 0, lat: L};

    // Reset state
    #12;
    check("reset_quociente", int'(Quociente), 0);
    check("reset_resto", int'(Resto), 0);
    check("reset_ocupado", int'(Ocupado), 0);
    check("reset_pronto", int'(Pronto), 0);
    check("reset_divzero", int'(DivZero), 0);
    @(negedge Clock);
    Reset = 1'b1;

    // Table vectors: hand-derived expectations also cross-check the model.
    foreach (vecs[i]) begin
      logic [EW-1:0] m;
      m = model(vecs[i].a, vecs[i].b);
      check("model_vs_table", int'(m), (vecs[i].dz << (2 * L)) | (vecs[i].q << L) | vecs[i].r);
      run_op(vecs[i].a, vecs[i].b, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Reset mid-operation: 11/2 aborted after edge 2, no Pronto.
    @(negedge Clock);
    Iniciar   = 1'b1;
    Dividendo = 4'd11;
    Divisor   = 4'd2;
    @(posedge Clock);
    #1 Iniciar = 1'b0;
    @(posedge Clock);
    @(posedge Clock);
    #2 Reset = 1'b0;
    #1;
    check("abort_quociente", int'(Quociente), 0);
    check("abort_resto", int'(Resto), 0);
    check("abort_ocupado", int'(Ocupado), 0);
    check("abort_pronto", int'(Pronto), 0);
    check("abort_divzero", int'(DivZero), 0);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (8) @(negedge Clock);
    check("abort_still_idle", int'(Ocupado), 0);
    run_op(11, 2, L, "after_abort");

    // Iniciar held high with operands changed during DIVIDE.
    exp_q.push_back(model(14, 4));
    expected_cnt++;
    @(negedge Clock);
    Iniciar   = 1'b1;
    Dividendo = 4'd14;
    Divisor   = 4'd4;
    @(posedge Clock);
    #1;
    Dividendo = 4'd3;
    Divisor   = 4'd3;
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge Clock);
        check("hold_busy", int'(Ocupado), 1);
        if (Pronto) begin
          found = 1'b1;
          break;
        end
      end
      if (!found) begin
        checks++;
        failures++;
        $display("FAIL hold_timeout: got no pronto expected pronto within 20 cycles");
      end
    end
    // Iniciar still high through FIM: must return to idle, not restart.
    @(negedge Clock);
    check("hold_no_restart_in_fim", int'(Ocupado), 0);
    Iniciar = 1'b0;

    // Exhaustive operand pairs in shuffled order with random idle gaps.
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j;
      int t;
      j = $urandom_range(0, i);
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      int a;
      int b;
      a = order[i] / 16;
      b = order[i] % 16;
      run_op(a, b, (b == 0) ? 0 : L, $sformatf("ex_%0d_%0d", a, b));
      repeat ($urandom_range(0, 2)) @(posedge Clock);
    end

    repeat (3) @(negedge Clock);
    check("scoreboard_drained", exp_q.size(), 0);
    check("pronto_count", pronto_cnt, expected_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
